// File: rtl/activate_handshake.sv
// activate_handshake: turns the level-coded HPS activate word into one-cycle
// start/abort pulses for the image-filter engine. It watches the engine with a
// timeout counter and reports {timeout, error, done, busy} plus a job counter.
//
// Handshake: software raises request (activate[0]) and keeps it high until
// status shows done or error. It then drops request, and abort (activate[1])
// as well after an error. The block returns to IDLE only after that drop, so a
// new job always needs a fresh 0->1 edge on request.
module activate_handshake #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] activate,
    input  logic       engine_done,
    output logic       engine_start,
    output logic       engine_abort,
    output logic [3:0] status,
    output logic [7:0] job_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_ERROR
    } state_t;

    // Counter value on the last BUSY cycle before a forced abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       act_m, act_s, act_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       job_q, job_d;
    logic             req_rise;

    // Request edge seen against the previous synchronized sample. The edge
    // register updates in every state, so edges outside IDLE are consumed.
    assign req_rise = act_s[0] & ~act_q[0];

    assign engine_start = start_q;
    assign engine_abort = abort_q;
    assign status       = {timeout_q, error_q, done_q, busy_q};
    assign job_count    = job_q;

    // Two-flop synchronizer for the activate word, plus its delayed copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_m <= 2'b00;
            act_s <= 2'b00;
            act_q <= 2'b00;
        end else begin
            act_m <= activate;
            act_s <= act_m;
            act_q <= act_s;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            job_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            job_q     <= job_d;
        end
    end

    // Next state and next output values. Pulses default low and sticky flags
    // default to holding their current value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        job_d     = job_q;
        case (state_q)
            S_IDLE: begin
                if (req_rise && !act_s[1]) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (act_s[1]) begin
                    abort_d = 1'b1;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else if (engine_done) begin
                    job_d   = job_q + 8'd1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d   = 1'b1;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    // Counter never runs past the compare point.
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!act_s[0]) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (act_s == 2'b00) begin
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/activate_handshake.md
# activate_handshake

Control-handshake stage directly downstream of the 2-bit HPS ACTIVATE output port. Converts the level-coded activate word written by software into single-cycle start/abort pulses for the image-filter engine. Supervises the engine with a timeout counter and returns a 4-bit status word and a job counter for an HPS-readable PIO input. Implements a 4-phase request/acknowledge protocol, so software never needs to time pulses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum BUSY duration before forced abort; legal range 2..2^24-1.
- CNT_W, 24: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- activate  in  2  from the ACTIVATE PIO; bit0 = request (level), bit1 = abort (level).
- engine_done  in  1  engine completion pulse/level; sampled only in BUSY.
- engine_start  out  1  one-cycle start pulse to the engine.
- engine_abort  out  1  one-cycle abort pulse to the engine.
- status  out  4  {timeout, error, done, busy}, to a PIO input.
- job_count  out  8  completed-job counter, wraps 255 -> 0.

## Operation
- activate passes through a 2-FF synchronizer (act_s). Edge detection uses act_s against a registered copy.
- States: IDLE, START, BUSY, DONE, ERROR.
- IDLE:
  - A rising edge on act_s[0] while act_s[1]=0 -> START.
  - A rising edge while act_s[1]=1 is ignored, and the edge is consumed.
- START: engine_start=1 for exactly this cycle; clear timeout counter -> BUSY.
- BUSY: counter increments every cycle. Priority, highest first:
  - act_s[1]=1 -> engine_abort pulse, error=1 -> ERROR.
  - engine_done=1 -> job_count+1, done=1 -> DONE.
  - counter == TIMEOUT_CYCLES-1 -> engine_abort pulse, error=1, timeout=1 -> ERROR.
  - otherwise stay in BUSY.
- DONE: hold done=1 until act_s[0]=0, then clear done -> IDLE.
- ERROR: hold error (and timeout, if set) until act_s[0]=0 and act_s[1]=0, then clear both -> IDLE.
- busy = 1 in START and BUSY, else 0.
- job_count: 8-bit modulo increment only on the BUSY->DONE transition. It is never cleared except by reset.
- engine_done outside BUSY is ignored.
- A request still high on return to IDLE does not restart; a fresh 0->1 edge is required.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release via the same flops):
  - state = IDLE.
  - engine_start = 0, engine_abort = 0.
  - status = 4'b0000, job_count = 0.
  - synchronizer and edge registers = 0.
- Latency, activate[0] rise -> engine_start high: 3 clk edges (2 sync + 1 edge/FSM). busy rises on the same edge as engine_start.
- engine_done sampled high in BUSY -> status.done high and busy low on the next edge.
- engine_start and engine_abort are registered and never high simultaneously. Each is high for exactly one cycle per event.
- Timeout: with start on cycle S (the START cycle), ERROR is entered at S+1+TIMEOUT_CYCLES if no done or abort arrives.
- Reset mid-BUSY: all outputs return to reset values immediately. No abort pulse is emitted; the engine receives its own reset.
- Counter width: unsigned CNT_W. The counter saturates logically at the compare point and never wraps.

## Test plan
- Reset then activate=01: engine_start pulses 3 cycles later, status=0001. Assert engine_done after 10 cycles -> status=0010, job_count=1. activate=00 -> status=0000 after sync delay.
- TIMEOUT_CYCLES=16, activate=01, never assert done: engine_abort pulses 17 cycles after engine_start, status=1100. activate=00 -> status=0000.
- In BUSY, drive activate=11 and engine_done on the same synchronized cycle: abort wins, status=0100, job_count unchanged.
- activate=11 from IDLE: no engine_start. Then activate=01 (no new edge on bit0): still no start. Then 00 -> 01: start pulses.
- 256 back-to-back complete jobs: job_count wraps 255 -> 0. engine_done pulses while IDLE/DONE are ignored.
- Assert reset_n=0 mid-BUSY: busy, engine_start, engine_abort and status go 0 asynchronously, job_count=0. After release, a new request edge starts normally.
